uart_ir_demod: RTL and testbench
================================

// Module: uart_ir_demod
// PURPOSE
//  IR carrier demodulator: the receive-side counterpart of the UART IR modulator.
//  Takes a raw, carrier-modulated IR line and produces a baseband UART level.
//  Carrier present = space (0). Carrier absent = mark/idle (1).
//  Sits between the rx pad and the UART RX path; configured from the UART register block.
// PARAMETERS
//  W_DIV   12  width of ir_div (same encoding as TX local osc: half-period = ir_div+1 clk)
//  W_TMO   16  width of carrier-loss timeout
//  W_EDGE  3   width of min_edges and the edge counter
// PORTS
//  clk         in   1      system clock
//  rst_n_sync  in   1      reset, asynchronous, active-low
//  en          in   1      enable; 0 = synchronous clear of all state
//  rx_raw      in   1      raw IR input, asynchronous to clk
//  invert_in   in   1      invert rx_raw after synchronisation
//  ir_div      in   W_DIV  expected carrier half-period minus 1, in clk cycles
//  tmo         in   W_TMO  carrier-loss timeout, in clk cycles after the last valid edge
//  min_edges   in   W_EDGE valid rising edges needed to declare carrier (0 treated as 1)
//  din         out  1      demodulated baseband, registered
//  carrier_det out  1      1 while in LOCK, registered
//  edge_err    out  1      1-cycle pulse on an out-of-window edge (FREQCHK build only)
// BEHAVIOUR
//  Reset/en=0: state=IDLE, din=1, carrier_det=0, edge_err=0, all counters 0.
//  Input path: 2-flop sync_1bit, then XOR with invert_in, giving rx_s.
//    Rising edge = rx_s & ~rx_s_q.
//  Period counter: clears on each rising edge, else increments and saturates at all-ones.
//    Width W_DIV+2.
//  P = 2*(ir_div+1). TOL = (ir_div+1)>>1. Window = [P-TOL, P+TOL], inclusive.
//    All arithmetic is unsigned, W_DIV+2 bits.
//  Valid edge:
//    - In IDLE: any rising edge is valid.
//    - Elsewhere: a rising edge is valid if the period is inside the window.
//      Without the FREQCHK build, every rising edge is valid.
//  Timer: loaded with tmo on every valid edge. Otherwise decrements while nonzero.
//  FSM, all transitions on clk:
//    IDLE: valid edge -> edge_cnt=1, timer=tmo.
//          Goes to LOCK if min_edges<=1, else to ACQ.
//    ACQ:  valid edge -> edge_cnt++.
//            Goes to LOCK when edge_cnt+1 >= min_edges.
//          invalid edge -> edge_cnt=1, timer=tmo, edge_err=1.
//            The edge restarts acquisition; stay in ACQ.
//          timer==0 and no edge -> IDLE, edge_cnt=0.
//    LOCK: valid edge -> reload timer.
//          invalid edge -> edge_err=1, timer not reloaded, stay in LOCK.
//          timer==0 and no edge -> IDLE, edge_cnt=0.
//  edge_cnt saturates at 2^W_EDGE-1.
//  An edge on the same cycle as timer==0 takes priority, so no drop occurs.
//  din = ~(next state==LOCK) and carrier_det = (next state==LOCK).
//    Both are registered together with the state.
//  Latency, rx_raw qualifying rise to din falling: 3 clk.
//  Latency, last valid edge to din rising: 2+tmo+1 clk.
//  tmo=0: LOCK is held for exactly 1 cycle after each valid edge.
//  en falling mid-LOCK: din=1 and carrier_det=0 on the next clk.
// CONFIGURATION
//  Macro UART_IR_DEMOD_FREQCHK_EN controls period-window qualification.
//  Defined:
//    - Period-window qualification and edge_err are active.
//    - Rejects ambient light flicker and off-frequency remotes.
//  Undefined:
//    - Every rising edge is valid.
//    - edge_err is tied to 0.
//    - The period counter and window comparator are removed.
// STRUCTURE
//  Shared header uart_ir_defs.vh (package role):
//    - FSM encodings IR_IDLE=0, IR_ACQ=1, IR_LOCK=2.
//    - IR_TOL_SHIFT=1.
//    - Default W_DIV/W_TMO.
//    The same header is used by the IR modulator.
//  Sub-module uart_ir_period_check: period counter + window compare.
//    Inputs: rise, ir_div. Output: in_window.
//    Instantiated only under UART_IR_DEMOD_FREQCHK_EN.
//  Reuse sync_1bit for input synchronisation.
// TESTING (ir_div=9 -> P=20, window [15,25]; tmo=50; min_edges=3; FREQCHK defined unless noted)
//  1. rx_raw toggles every 10 clk for 10 periods, then held 1.
//     -> din falls 3 clk after the 3rd rise; rises 53 clk after the last rise.
//     -> carrier_det mirrors ~din.
//  2. rx_raw toggles every 20 clk (P=40).
//     -> never LOCK; edge_err pulses on every rise after the first.
//     Undefined build: LOCK after the 3rd rise.
//  3. Single 2-clk high glitch.
//     -> ACQ, back to IDLE 50 clk later; din stays 1; edge_err stays 0.
//  4. invert_in=1, inverted stimulus of test 1.
//     -> identical din/carrier_det waveform.
//  5. en=0 for 1 clk during LOCK.
//     -> din=1 and carrier_det=0 next clk; relocks only after 3 new valid rises.
//  6. Loopback: UART TX in IR mode (ir_div=9, div 16x baud) sends 0x55 into rx_raw.
//     -> din reproduces tx_q (start, 10101010, stop) within 3 clk skew per bit,
//        plus up to tmo on mark edges.

Source files
------------

// File: rtl/uart_ir_demod_pkg.sv
// ----------------------------------------------------------------------------
// uart_ir_demod_pkg
//   Shared definitions for the UART IR carrier path (modulator and demodulator).
//   Holds the demodulator FSM encoding, the window tolerance shift and the
//   default widths of the divider and timeout fields.
// ----------------------------------------------------------------------------
package uart_ir_demod_pkg;

  typedef enum logic [1:0] {
    IR_IDLE = 2'd0,
    IR_ACQ  = 2'd1,
    IR_LOCK = 2'd2
  } ir_state_e;

  // Tolerance of the period window is (ir_div+1) >> IR_TOL_SHIFT,
  // i.e. a quarter of the nominal carrier period.
  localparam int IR_TOL_SHIFT  = 1;

  localparam int IR_W_DIV_DEF  = 12;
  localparam int IR_W_TMO_DEF  = 16;
  localparam int IR_W_EDGE_DEF = 3;

endpackage

// File: rtl/sync_1bit.sv
// ----------------------------------------------------------------------------
// sync_1bit
//   Two-flop synchroniser for a single asynchronous level.
// Ports
//   clk        in  system clock
//   rst_n_sync in  asynchronous active-low reset (output clears to 0)
//   d          in  asynchronous input
//   q          out synchronised level, two clk cycles behind d
// ----------------------------------------------------------------------------
module sync_1bit (
  input  logic clk,
  input  logic rst_n_sync,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_ir_period_check.sv
// ----------------------------------------------------------------------------
// uart_ir_period_check
//   Measures the distance between successive rising edges of the synchronised
//   IR line and flags whether the current edge falls inside the expected
//   carrier period window [P-TOL, P+TOL], P = 2*(ir_div+1),
//   TOL = (ir_div+1) >> IR_TOL_SHIFT.
// Ports
//   clk        in  system clock
//   rst_n_sync in  asynchronous active-low reset
//   en         in  0 = synchronous clear of the period counter
//   rise       in  rising edge of the synchronised line (this cycle)
//   ir_div     in  expected carrier half-period minus 1, in clk cycles
//   in_window  out combinational: period ending at this cycle is in window
// ----------------------------------------------------------------------------
module uart_ir_period_check
  import uart_ir_demod_pkg::*;
#(
  parameter int W_DIV = IR_W_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             en,
  input  logic             rise,
  input  logic [W_DIV-1:0] ir_div,
  output logic             in_window
);

  localparam int W_CNT = W_DIV + 2;

  logic [W_CNT-1:0] cnt_q;
  logic [W_CNT-1:0] period;
  logic [W_CNT-1:0] half;
  logic [W_CNT-1:0] nominal;
  logic [W_CNT-1:0] tol;
  logic [W_CNT-1:0] lo;
  logic [W_CNT-1:0] hi;

  // Counts clk cycles since the last rising edge; saturates so that a very
  // long gap reads as "far too long" instead of wrapping into the window.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      cnt_q <= '0;
    end else if (!en || rise) begin
      cnt_q <= '0;
    end else if (!(&cnt_q)) begin
      cnt_q <= cnt_q + W_CNT'(1);
    end
  end

  // The counter reads 0 on the cycle after an edge, so the edge-to-edge
  // distance ending at this cycle is cnt_q+1 (held at all-ones once saturated).
  assign period  = (&cnt_q) ? cnt_q : cnt_q + W_CNT'(1);

  assign half    = {2'b00, ir_div} + W_CNT'(1);
  assign nominal = half << 1;
  assign tol     = half >> IR_TOL_SHIFT;
  assign lo      = nominal - tol;
  assign hi      = nominal + tol;

  assign in_window = (period >= lo) && (period <= hi);

endmodule

// File: rtl/uart_ir_demod.sv
// ----------------------------------------------------------------------------
// uart_ir_demod
//   IR carrier demodulator. Converts a raw carrier-modulated IR line into a
//   baseband UART level: carrier present = space (0), carrier absent = mark (1).
//   Build option: define UART_IR_DEMOD_FREQCHK_EN to qualify edges against the
//   expected carrier period and report out-of-window edges on edge_err.
//   Without it every rising edge counts as carrier and edge_err is 0.
// Ports
//   clk         in  system clock
//   rst_n_sync  in  asynchronous active-low reset
//   en          in  0 = synchronous clear of all state
//   rx_raw      in  raw IR input, asynchronous to clk
//   invert_in   in  invert rx_raw after synchronisation
//   ir_div      in  expected carrier half-period minus 1, in clk cycles
//   tmo         in  carrier-loss timeout, clk cycles after last valid edge
//   min_edges   in  valid rising edges needed to declare carrier (0 acts as 1)
//   din         out demodulated baseband, registered
//   carrier_det out 1 while locked, registered
//   edge_err    out 1-cycle pulse on an out-of-window edge
// ----------------------------------------------------------------------------
module uart_ir_demod
  import uart_ir_demod_pkg::*;
#(
  parameter int W_DIV  = IR_W_DIV_DEF,
  parameter int W_TMO  = IR_W_TMO_DEF,
  parameter int W_EDGE = IR_W_EDGE_DEF
) (
  input  logic              clk,
  input  logic              rst_n_sync,
  input  logic              en,
  input  logic              rx_raw,
  input  logic              invert_in,
  input  logic [W_DIV-1:0]  ir_div,
  input  logic [W_TMO-1:0]  tmo,
  input  logic [W_EDGE-1:0] min_edges,
  output logic              din,
  output logic              carrier_det,
  output logic              edge_err
);

  ir_state_e         state_q, state_d;
  logic [W_EDGE-1:0] edge_cnt, edge_cnt_d;
  logic [W_TMO-1:0]  timer_q, timer_d;
  logic              err_q, err_d;

  logic              rx_sync;
  logic              rx_s;
  logic              rx_s_q;
  logic              rise;
  logic              valid;

  logic [W_EDGE-1:0] min_eff;
  logic [W_EDGE:0]   cnt_inc;
  logic [W_EDGE-1:0] cnt_sat;
  logic              reach;
  logic              timer_zero;
  logic [W_TMO-1:0]  timer_dec;

  sync_1bit u_sync (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .d          (rx_raw),
    .q          (rx_sync)
  );

  assign rx_s = rx_sync ^ invert_in;

  // Edge-detector history keeps following the line while disabled so that
  // re-enabling on a high level does not fabricate a rising edge.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rx_s_q <= 1'b0;
    end else begin
      rx_s_q <= rx_s;
    end
  end

  assign rise = rx_s & ~rx_s_q;

`ifdef UART_IR_DEMOD_FREQCHK_EN
  logic in_window;

  uart_ir_period_check #(
    .W_DIV (W_DIV)
  ) u_period (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .en         (en),
    .rise       (rise),
    .ir_div     (ir_div),
    .in_window  (in_window)
  );

  // The first edge out of IDLE has no reference period, so it is always taken.
  assign valid    = (state_q == IR_IDLE) | in_window;
  assign edge_err = err_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{ir_div, err_q};
  assign valid      = 1'b1;
  assign edge_err   = 1'b0;
`endif

  assign min_eff    = (min_edges == '0) ? W_EDGE'(1) : min_edges;
  assign cnt_inc    = {1'b0, edge_cnt} + (W_EDGE+1)'(1);
  assign cnt_sat    = (&edge_cnt) ? edge_cnt : cnt_inc[W_EDGE-1:0];
  assign reach      = cnt_inc >= {1'b0, min_eff};
  assign timer_zero = (timer_q == '0);
  assign timer_dec  = timer_zero ? timer_q : timer_q - W_TMO'(1);

  // Next-state logic. An edge always wins over a simultaneous timeout.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt;
    timer_d    = timer_dec;
    err_d      = 1'b0;
    case (state_q)
      IR_IDLE: begin
        if (rise) begin
          edge_cnt_d = W_EDGE'(1);
          timer_d    = tmo;
          state_d    = (min_eff == W_EDGE'(1)) ? IR_LOCK : IR_ACQ;
        end
      end
      IR_ACQ: begin
        if (rise) begin
          timer_d = tmo;
          if (valid) begin
            edge_cnt_d = cnt_sat;
            if (reach) begin
              state_d = IR_LOCK;
            end
          end else begin
            edge_cnt_d = W_EDGE'(1);
            err_d      = 1'b1;
          end
        end else if (timer_zero) begin
          state_d    = IR_IDLE;
          edge_cnt_d = '0;
        end
      end
      IR_LOCK: begin
        if (rise) begin
          if (valid) begin
            timer_d = tmo;
          end else begin
            err_d = 1'b1;
          end
        end else if (timer_zero) begin
          state_d    = IR_IDLE;
          edge_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IR_IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  // State, counters and the outputs are registered together, with the outputs
  // decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q     <= IR_IDLE;
      edge_cnt    <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      din         <= 1'b1;
      carrier_det <= 1'b0;
    end else if (!en) begin
      state_q     <= IR_IDLE;
      edge_cnt    <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      din         <= 1'b1;
      carrier_det <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt    <= edge_cnt_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      din         <= ~(state_d == IR_LOCK);
      carrier_det <= (state_d == IR_LOCK);
    end
  end

endmodule

// File: tb/tb_uart_ir_demod.sv
// ----------------------------------------------------------------------------
// tb_uart_ir_demod
//   Self-checking bench for uart_ir_demod. Directed carrier patterns plus
//   randomized bursts are driven into rx_raw; a time-based reference model
//   predicts din/carrier_det/edge_err every cycle. Honours the
//   UART_IR_DEMOD_FREQCHK_EN build option.
// ----------------------------------------------------------------------------
module tb_uart_ir_demod;

  localparam int MAXC    = 20000;
  localparam int CNT_SAT = 16383;
  localparam int M_IDLE  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_LOCK  = 2;

  logic        clk = 1'b0;
  logic        rst_n_sync;
  logic        en;
  logic        rx_raw;
  logic        invert_in;
  logic [11:0] ir_div;
  logic [15:0] tmo;
  logic [2:0]  min_edges;
  logic        din;
  logic        carrier_det;
  logic        edge_err;

  // Values to be applied on the next cycle
  bit          nRst, nEn, nInv, nRaw;
  int          nDiv, nTmo, nMin;

  bit          hRaw [MAXC];
  bit          hInv [MAXC];

  int          checks, errors, cyc;
  int          errPulses, cdCycles;

  int          mMode, mCnt, mLoadAt, mLoadTmo, mLastClr;
  bit          expDin, expCd, expErr;

  always #5 clk = ~clk;

  uart_ir_demod dut (
    .clk         (clk),
    .rst_n_sync  (rst_n_sync),
    .en          (en),
    .rx_raw      (rx_raw),
    .invert_in   (invert_in),
    .ir_div      (ir_div),
    .tmo         (tmo),
    .min_edges   (min_edges),
    .din         (din),
    .carrier_det (carrier_det),
    .edge_err    (edge_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Synchronised, inverted line level: raw during cycle k, inversion during kinv
  function automatic bit rxs(input int k, input int kinv);
    bit r, i;
    r = (k < 0) ? 1'b0 : hRaw[k];
    i = (kinv < 0) ? 1'b0 : hInv[kinv];
    return r ^ i;
  endfunction

  // Reference model evaluated at each rising clk edge, from the inputs seen
  // during the preceding cycle. Timer is tracked as "load time + loaded tmo".
  task automatic modelStep();
    int c, period, half, nomP, tol, minEff;
    bit riseNow, inWin, valid, tz;
    c       = cyc;
    riseNow = rxs(c-3, c-1) && !rxs(c-4, c-2);
    expErr  = 1'b0;
    if (!rst_n_sync || !en) begin
      mMode    = M_IDLE;
      mCnt     = 0;
      mLoadAt  = c;
      mLoadTmo = 0;
      mLastClr = c;
    end else begin
      period = c - mLastClr;
      if (period > CNT_SAT) period = CNT_SAT;
      half  = int'(ir_div) + 1;
      nomP  = 2 * half;
      tol   = half / 2;
      inWin = (period >= nomP - tol) && (period <= nomP + tol);
      valid = 1'b1;
`ifdef UART_IR_DEMOD_FREQCHK_EN
      valid = (mMode == M_IDLE) || inWin;
`endif
      tz     = (c - 1 - mLoadAt) >= mLoadTmo;
      minEff = (min_edges == 0) ? 1 : int'(min_edges);
      if (riseNow) begin
        mLastClr = c;
        if (mMode == M_IDLE) begin
          mCnt     = 1;
          mLoadAt  = c;
          mLoadTmo = int'(tmo);
          mMode    = (minEff <= 1) ? M_LOCK : M_ACQ;
        end else if (valid) begin
          if (mMode == M_ACQ) begin
            if (mCnt + 1 >= minEff) mMode = M_LOCK;
            mCnt = (mCnt < 7) ? mCnt + 1 : 7;
          end
          mLoadAt  = c;
          mLoadTmo = int'(tmo);
        end else begin
          expErr = 1'b1;
          if (mMode == M_ACQ) begin
            mCnt     = 1;
            mLoadAt  = c;
            mLoadTmo = int'(tmo);
          end
        end
      end else if (mMode != M_IDLE && tz) begin
        mMode = M_IDLE;
        mCnt  = 0;
      end
    end
    expDin = (mMode != M_LOCK);
    expCd  = (mMode == M_LOCK);
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep();
    #1;
    rst_n_sync = nRst;
    en         = nEn;
    rx_raw     = nRaw;
    invert_in  = nInv;
    ir_div     = 12'(nDiv);
    tmo        = 16'(nTmo);
    min_edges  = 3'(nMin);
    hRaw[cyc]  = nRaw;
    hInv[cyc]  = nInv;
    @(negedge clk);
    checkOutput("din", 32'(din), 32'(expDin));
    checkOutput("carrier_det", 32'(carrier_det), 32'(expCd));
    checkOutput("edge_err", 32'(edge_err), 32'(expErr));
    if (edge_err === 1'b1) errPulses++;
    if (carrier_det === 1'b1) cdCycles++;
    cyc++;
    if (cyc >= MAXC) begin
      $display("[TB] FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
  endtask

  task automatic applyStimulus(input bit raw, input int n);
    for (int i = 0; i < n; i++) begin
      nRaw = raw;
      runCycle();
    end
  endtask

  task automatic carrierBurst(input int halfLen, input int periods, input bit inv);
    for (int k = 0; k < periods; k++) begin
      applyStimulus(1'b1 ^ inv, halfLen);
      applyStimulus(1'b0 ^ inv, halfLen);
    end
  endtask

  initial begin
    int pulses, base, hiLen, loLen;
    checks = 0; errors = 0; cyc = 0; errPulses = 0; cdCycles = 0;
    mMode = M_IDLE; mCnt = 0; mLoadAt = 0; mLoadTmo = 0; mLastClr = 0;
    expDin = 1'b1; expCd = 1'b0; expErr = 1'b0;
    nRst = 1'b0; nEn = 1'b1; nInv = 1'b0; nRaw = 1'b0;
    nDiv = 9; nTmo = 50; nMin = 3;
    rst_n_sync = 1'b0; en = 1'b1; rx_raw = 1'b0; invert_in = 1'b0;
    ir_div = 12'd9; tmo = 16'd50; min_edges = 3'd3;

    $display("[TB] reset");
    applyStimulus(1'b0, 4);
    nRst = 1'b1;
    applyStimulus(1'b0, 20);

    $display("[TB] nominal carrier burst");
    carrierBurst(10, 10, 1'b0);
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 120);

    $display("[TB] double-period carrier");
    errPulses = 0; cdCycles = 0;
    carrierBurst(20, 10, 1'b0);
`ifdef UART_IR_DEMOD_FREQCHK_EN
    checkOutput("t2_err_pulses", 32'(errPulses), 32'd9);
    checkOutput("t2_lock_cycles", 32'(cdCycles), 32'd0);
`else
    checkOutput("t2_err_pulses", 32'(errPulses), 32'd0);
    checkOutput("t2_locked", 32'(cdCycles > 0), 32'd1);
`endif
    applyStimulus(1'b0, 120);

    $display("[TB] single glitch");
    errPulses = 0; cdCycles = 0;
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 100);
    checkOutput("t3_err_pulses", 32'(errPulses), 32'd0);
    checkOutput("t3_lock_cycles", 32'(cdCycles), 32'd0);

    $display("[TB] inverted input");
    nInv = 1'b1;
    applyStimulus(1'b1, 30);
    carrierBurst(10, 10, 1'b1);
    applyStimulus(1'b1, 120);
    nInv = 1'b0;
    applyStimulus(1'b0, 30);

    $display("[TB] enable drop during lock");
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        applyStimulus(1'b1, 5);
        nEn = 1'b0;
        applyStimulus(1'b1, 1);
        nEn = 1'b1;
        applyStimulus(1'b1, 4);
      end else begin
        applyStimulus(1'b1, 10);
      end
      applyStimulus(1'b0, 10);
    end
    applyStimulus(1'b0, 120);

    $display("[TB] zero timeout");
    nTmo = 0; nMin = 1;
    applyStimulus(1'b0, 5);
    errPulses = 0; cdCycles = 0;
    carrierBurst(10, 5, 1'b0);
    checkOutput("tmo0_lock_cycles", 32'(cdCycles), 32'd5);
    checkOutput("tmo0_err_pulses", 32'(errPulses), 32'd0);
    applyStimulus(1'b0, 20);

    $display("[TB] window boundaries");
    nTmo = 50; nMin = 3;
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 7);  applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 12); applyStimulus(1'b0, 13);
    applyStimulus(1'b1, 7);  applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 12); applyStimulus(1'b0, 13);
    applyStimulus(1'b1, 7);  applyStimulus(1'b0, 7);
    applyStimulus(1'b1, 13); applyStimulus(1'b0, 13);
    applyStimulus(1'b1, 10); applyStimulus(1'b0, 120);

    $display("[TB] randomized bursts");
    for (int r = 0; r < 8; r++) begin
      nDiv = int'($urandom_range(2, 12));
      nTmo = int'($urandom_range(0, 40));
      nMin = int'($urandom_range(0, 7));
      nInv = 1'($urandom_range(0, 1));
      applyStimulus(nInv, 30);
      pulses = int'($urandom_range(4, 16));
      base   = nDiv + 1;
      for (int k = 0; k < pulses; k++) begin
        hiLen = base - base / 2 + int'($urandom_range(0, base));
        loLen = base - base / 2 + int'($urandom_range(0, base));
        if ($urandom_range(0, 9) == 0) loLen += int'($urandom_range(20, 80));
        if ($urandom_range(0, 19) == 0) begin
          nEn = 1'b0;
          applyStimulus(1'b1 ^ nInv, 1);
          nEn = 1'b1;
        end
        applyStimulus(1'b1 ^ nInv, hiLen);
        applyStimulus(1'b0 ^ nInv, loLen);
      end
      applyStimulus(nInv, 80);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
